// File: rtl/mux_rr_scheduler_pkg.sv
// Shared definitions for the round-robin mux scheduler: FSM state encoding
// and default sizing.
`default_nettype none

package mux_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage

`default_nettype wire

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning from last+1 upward, wrapping at N_REQ.
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] w_pos;

    // Scan from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        idx   = '0;
        w_pos = '0;
        any   = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            w_pos = SEL_W'((int'(last) + k) % N_REQ);
            if (req[w_pos]) begin
                idx = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler driving a 4:1 mux select, with a one-cycle
// break-before-make gap. Define MUX_SCHED_TIMEOUT_EN to bound grant length.
`default_nettype none

module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int SEL_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] D,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] S,
    output logic             Y,
    output logic             busy
);

    if (N_REQ < 2 || N_REQ > 4 || MAX_HOLD < 1) begin : g_param_check
        $error("mux_rr_scheduler: N_REQ must be 2..4 and MAX_HOLD >= 1");
    end

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             busy_q, busy_d;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             timeout;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req  (req),
        .last (last_q),
        .idx  (pick_idx),
        .any  (pick_any)
    );

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // hold_q is 0 in the first grant cycle, so MAX_HOLD-1 marks the last one.
    assign timeout = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        busy_d  = busy_q;
`ifdef MUX_SCHED_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_any) begin
                    state_d         = ST_GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    sel_d           = pick_idx;
                    busy_d          = 1'b1;
`ifdef MUX_SCHED_TIMEOUT_EN
                    hold_d          = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                // Other requesters are not looked at here: no preemption.
                if (!req[sel_q] || timeout) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    last_d  = sel_q;
                end
`ifdef MUX_SCHED_TIMEOUT_EN
                else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign S    = sel_q;
    assign busy = busy_q;
    assign Y    = (|gnt_q) ? D[sel_q] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: stimulus queues expected outputs,
// a monitor pops and compares them after each rising edge.
`default_nettype none

module tb_mux_rr_scheduler;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] s;
        logic       busy;
        logic       y;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'hF;
    logic [3:0] D   = 4'h0;
    logic [3:0] gnt;
    logic [1:0] S;
    logic       Y;
    logic       busy;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    mux_rr_scheduler #(
        .N_REQ    (4),
        .SEL_W    (2),
        .MAX_HOLD (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .D    (D),
        .gnt  (gnt),
        .S    (S),
        .Y    (Y),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b required %b", nm, got, want);
        end
    endtask

    // Drive inputs for the coming edge and queue what must appear after it.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d,
                        input logic [3:0] eg, input logic [1:0] es, input logic eb,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        D   = d;
        e.gnt  = eg;
        e.s    = es;
        e.busy = eb;
        e.y    = (eg != 4'h0) ? d[es] : 1'b0;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".gnt"},  gnt,          e.gnt);
                chk({e.name, ".S"},    {2'b00, S},   {2'b00, e.s});
                chk({e.name, ".busy"}, {3'b000, busy}, {3'b000, e.busy});
                chk({e.name, ".Y"},    {3'b000, Y},  {3'b000, e.y});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         o;
        logic [3:0] oh;

        // 1: reset held with all requesting, then release
        #1;
        chk("rst_async.gnt", gnt, 4'h0);
        chk("rst_async.busy", {3'b000, busy}, 4'h0);
        step(1'b1, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, "rst_hold0");
        step(1'b1, 4'hF, 4'hF, 4'h0, 2'd0, 1'b0, "rst_hold1");
        step(1'b0, 4'hF, 4'h0, 4'b0001, 2'd0, 1'b1, "rst_release");
        step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, "rst_drop_gap");
        step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, "rst_idle");

        // 2: single requester 2
        step(1'b0, 4'b0100, 4'b1010, 4'b0100, 2'd2, 1'b1, "single_grant");
        step(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "single_hold");
        step(1'b0, 4'b0000, 4'b0100, 4'h0, 2'd2, 1'b0, "single_drop");
        step(1'b0, 4'b0000, 4'b0000, 4'h0, 2'd2, 1'b0, "single_idle");

        // Park the pointer at 3 so rotation starts at 0
        step(1'b0, 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, "park3_grant");
        step(1'b0, 4'b0000, 4'b0000, 4'h0, 2'd3, 1'b0, "park3_gap");
        step(1'b0, 4'b0000, 4'b0000, 4'h0, 2'd3, 1'b0, "park3_idle");

        // 3: rotation 0,1,2,3,0 with one gap between owners
        for (int k = 0; k < 5; k++) begin
            o  = k % 4;
            oh = 4'b0001 << o;
            step(1'b0, 4'hF, 4'b1010, oh, 2'(o), 1'b1, "rot_own_a");
            step(1'b0, 4'hF, 4'b1010, oh, 2'(o), 1'b1, "rot_own_b");
            step(1'b0, 4'hF, 4'b1010, oh, 2'(o), 1'b1, "rot_own_c");
            step(1'b0, 4'hF & ~oh, 4'b1010, 4'h0, 2'(o), 1'b0, "rot_gap");
        end
        step(1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, "rot_idle");

        // 4: wrap from 3 to 0, then skip 1 and 3
        step(1'b0, 4'b1000, 4'h0, 4'b1000, 2'd3, 1'b1, "wrap_park3");
        step(1'b0, 4'b0000, 4'h0, 4'h0, 2'd3, 1'b0, "wrap_park_gap");
        step(1'b0, 4'b0000, 4'h0, 4'h0, 2'd3, 1'b0, "wrap_park_idle");
        step(1'b0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, "wrap_to0");
        step(1'b0, 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, "wrap_hold0");
        step(1'b0, 4'b0100, 4'b0001, 4'h0, 2'd0, 1'b0, "wrap_gap");
        step(1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, "skip_to2");
        step(1'b0, 4'b0000, 4'b0100, 4'h0, 2'd2, 1'b0, "skip_gap");
        step(1'b0, 4'b0000, 4'h0, 4'h0, 2'd2, 1'b0, "skip_idle");

        // 5: two requesters held constant
`ifdef MUX_SCHED_TIMEOUT_EN
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, "to_own0");
        step(1'b0, 4'b0011, 4'b0010, 4'h0, 2'd0, 1'b0, "to_gap0");
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1, "to_own1");
        step(1'b0, 4'b0011, 4'b0010, 4'h0, 2'd1, 1'b0, "to_gap1");
        step(1'b0, 4'b0000, 4'b0010, 4'h0, 2'd1, 1'b0, "to_idle");
`else
        for (int k = 0; k < 18; k++) step(1'b0, 4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, "hold_own0");
        step(1'b0, 4'b0000, 4'b0010, 4'h0, 2'd0, 1'b0, "hold_gap");
        step(1'b0, 4'b0000, 4'b0010, 4'h0, 2'd0, 1'b0, "hold_idle");
`endif

        // 6: asynchronous reset while requester 1 owns the mux
        step(1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, "mid_grant1");
        step(1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, "mid_hold1");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.gnt", gnt, 4'h0);
        chk("mid_rst.busy", {3'b000, busy}, 4'h0);
        chk("mid_rst.S", {2'b00, S}, 4'h0);
        chk("mid_rst.Y", {3'b000, Y}, 4'h0);
        step(1'b1, 4'b0011, 4'b0001, 4'h0, 2'd0, 1'b0, "mid_rst_hold");
        step(1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, "mid_release");
        step(1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, "mid_hold0");
        step(1'b0, 4'b0000, 4'b0001, 4'h0, 2'd0, 1'b0, "mid_gap");

        repeat (3) @(negedge clk);
        chk("sb_drained", 4'(sb.size()), 4'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
